// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: per-register enables and flushes,
// plus saturating stall/flush performance counters.
module pipeline_ctrl #(
   parameter int REDIRECT_BUBBLES = 1,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use,
   input  logic             redirect,
   input  logic             trap_req,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      TRAP  = 2'd2
   } state_t;

   localparam int         BCNT_INIT_I = (REDIRECT_BUBBLES > 0) ? REDIRECT_BUBBLES - 1 : 0;
   localparam logic [1:0] BCNT_INIT   = 2'(BCNT_INIT_I);
   localparam state_t     AFTER_KILL  = (REDIRECT_BUBBLES > 0) ? FLUSH : RUN;

   state_t           r_state;
   state_t           w_nextState;
   logic [1:0]       r_bcnt;
   logic [1:0]       w_nextBcnt;
   logic             w_memStall;
   logic             w_stallInc;
   logic             w_flushInc;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;

   assign w_memStall = dmem_req & ~dmem_ready;

   // A memory stall freezes everything, including any pending redirect/trap sequence.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      w_nextState  = r_state;
      w_nextBcnt   = r_bcnt;
      w_stallInc   = 1'b0;
      w_flushInc   = 1'b0;
      if (!rst_n) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (w_memStall) begin
         pc_en      = 1'b0;
         if_id_en   = 1'b0;
         id_ex_en   = 1'b0;
         ex_mem_en  = 1'b0;
         mem_wb_en  = 1'b0;
         w_stallInc = 1'b1;
      end else if (trap_req) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         w_flushInc   = 1'b1;
         w_nextState  = TRAP;
      end else begin
         unique case (r_state)
            TRAP: begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               w_nextState = AFTER_KILL;
               w_nextBcnt  = BCNT_INIT;
            end
            FLUSH, RUN: begin
               if (redirect) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  w_flushInc  = 1'b1;
                  w_nextState = AFTER_KILL;
                  w_nextBcnt  = BCNT_INIT;
               end else if (r_state == FLUSH) begin
                  // IF/ID still holds a stale fetch word from before the redirect.
                  if_id_flush = 1'b1;
                  if (r_bcnt == 2'd0) begin
                     w_nextState = RUN;
                  end else begin
                     w_nextBcnt = r_bcnt - 2'd1;
                  end
               end else if (load_use) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
                  w_stallInc  = 1'b1;
               end
            end
            default: begin
               w_nextState = RUN;
               w_nextBcnt  = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_bcnt  <= 2'd0;
      end else begin
         r_state <= w_nextState;
         r_bcnt  <= w_nextBcnt;
      end
   end

   // Counters stick at all-ones so long runs never report a small wrapped value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (w_stallInc && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
         if (w_flushInc && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         end
      end
   end

   assign state     = r_state;
   assign stall_cnt = r_stallCnt;
   assign flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with narrow counters so saturation is reachable.
module tb_pipeline_ctrl;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             load_use;
   logic             redirect;
   logic             trap_req;
   logic             dmem_req;
   logic             dmem_ready;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic [4:0]       en;
   logic [2:0]       fl;
   int               checks;
   int               errors;

   assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
   assign fl = {if_id_flush, id_ex_flush, ex_mem_flush};

   pipeline_ctrl #(
      .REDIRECT_BUBBLES(1),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .load_use(load_use),
      .redirect(redirect),
      .trap_req(trap_req),
      .dmem_req(dmem_req),
      .dmem_ready(dmem_ready),
      .pc_en(pc_en),
      .if_id_en(if_id_en),
      .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush),
      .state(state),
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Step to just after the next rising edge, where registered state has settled.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic lu, input logic rd, input logic tr,
                                input logic dq, input logic dr);
      load_use   = lu;
      redirect   = rd;
      trap_req   = tr;
      dmem_req   = dq;
      dmem_ready = dr;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [4:0] expEn,
                              input logic [2:0] expFl, input logic [1:0] expState);
      checks++;
      if (en !== expEn) begin
         errors++;
         $display("[TB] FAIL %s en: got %b expected %b", name, en, expEn);
      end
      checks++;
      if (fl !== expFl) begin
         errors++;
         $display("[TB] FAIL %s flush: got %b expected %b", name, fl, expFl);
      end
      checks++;
      if (state !== expState) begin
         errors++;
         $display("[TB] FAIL %s state: got %0d expected %0d", name, state, expState);
      end
   endtask

   task automatic checkCounters(input string name, input logic [CNT_W-1:0] expStall,
                                input logic [CNT_W-1:0] expFlush);
      checks++;
      if (stall_cnt !== expStall) begin
         errors++;
         $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, expStall);
      end
      checks++;
      if (flush_cnt !== expFlush) begin
         errors++;
         $display("[TB] FAIL %s flush_cnt: got %0d expected %0d", name, flush_cnt, expFlush);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("reset_active", 5'b00000, 3'b111, 2'd0);
      checkCounters("reset_active", 4'd0, 4'd0);
      nextCycle();
      rst_n = 1'b1;
      #1;
      checkOutput("reset_release", 5'b11111, 3'b000, 2'd0);
      nextCycle();
      checkOutput("reset_idle", 5'b11111, 3'b000, 2'd0);
      checkCounters("reset_idle", 4'd0, 4'd0);
   endtask

   task automatic test_load_use();
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("load_use", 5'b00111, 3'b010, 2'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("load_use_after", 5'b11111, 3'b000, 2'd0);
      checkCounters("load_use_after", 4'd1, 4'd0);
   endtask

   task automatic test_redirect();
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("redirect_c0", 5'b11111, 3'b110, 2'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("redirect_c1", 5'b11111, 3'b100, 2'd1);
      nextCycle();
      checkOutput("redirect_c2", 5'b11111, 3'b000, 2'd0);
      checkCounters("redirect_c2", 4'd1, 4'd1);
      // Redirect beats load_use; load_use is then ignored inside FLUSH.
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("redirect_lu_c0", 5'b11111, 3'b110, 2'd0);
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("flush_lu_ignored", 5'b11111, 3'b100, 2'd1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("redirect_lu_c2", 5'b11111, 3'b000, 2'd0);
      checkCounters("redirect_lu_c2", 4'd1, 4'd2);
   endtask

   task automatic test_mem_stall();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 0);
         checkOutput("mem_stall", 5'b00000, 3'b000, 2'd0);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("mem_ready", 5'b11111, 3'b000, 2'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkCounters("mem_stall_done", 4'd4, 4'd2);
   endtask

   task automatic test_trap();
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput("trap_c0", 5'b11111, 3'b111, 2'd0);
      nextCycle();
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("trap_c1", 5'b11111, 3'b110, 2'd2);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("trap_c2", 5'b11111, 3'b100, 2'd1);
      nextCycle();
      checkOutput("trap_c3", 5'b11111, 3'b000, 2'd0);
      checkCounters("trap_c3", 4'd4, 4'd3);
   endtask

   task automatic test_flush_stall();
      applyStimulus(0, 1, 0, 0, 0);
      nextCycle();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 1, 0);
         checkOutput("flush_stall", 5'b00000, 3'b000, 2'd1);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("flush_resume", 5'b11111, 3'b100, 2'd1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("flush_stall_run", 5'b11111, 3'b000, 2'd0);
      checkCounters("flush_stall_run", 4'd6, 4'd4);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkCounters("stall_saturate", 4'd15, 4'd4);
   endtask

   task automatic test_reset_mid();
      applyStimulus(0, 1, 0, 0, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("pre_reset_flush", 5'b11111, 3'b100, 2'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("reset_mid", 5'b00000, 3'b111, 2'd0);
      checkCounters("reset_mid", 4'd0, 4'd0);
      nextCycle();
      rst_n = 1'b1;
      nextCycle();
      checkOutput("reset_mid_release", 5'b11111, 3'b000, 2'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_stall();
      test_trap();
      test_flush_stall();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
